ka_split_sched_48bit: RTL and testbench

Operand-side sequencer for one 48-bit Karatsuba GF(2) multiplication level.
- Accepts two 48-bit operands and splits each into a 24-bit low half, high half and low^high half.
- Issues the three 24x24 operand pairs one at a time to a shared sub-multiplier over a valid/ready handshake.
- Collects the three 47-bit carry-less sub-products, which may return in any order, and corrects the middle term.
- Presents the low, middle and high 47-bit terms held stable for the 95-bit overlap/recombination stage.

---
 rtl/ka_split_sched_48bit_if.sv | 34 +++
 rtl/ka_split_sched_48bit.sv | 184 ++++++++++++++++++
 tb/tb_ka_split_sched_48bit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ka_split_sched_48bit_if.sv
// rtl/ka_split_sched_48bit_if.sv - operand, sub-multiplier, product and result handshakes of the Karatsuba sequencer
interface ka_split_sched_48bit_if #(
  parameter int N = 48,
  parameter int H = N / 2
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             sub_valid;
  logic             sub_ready;
  logic [H-1:0]     sub_a;
  logic [H-1:0]     sub_b;
  logic [1:0]       sub_tag;
  logic             prod_valid;
  logic [2*H-2:0]   prod_in;
  logic [1:0]       prod_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*H-2:0]   p_lo;
  logic [2*H-2:0]   p_mid;
  logic [2*H-2:0]   p_hi;
  logic             err;

  modport slave (
    input  in_valid, a_in, b_in, sub_ready, prod_valid, prod_in, prod_tag, out_ready,
    output in_ready, sub_valid, sub_a, sub_b, sub_tag, out_valid, p_lo, p_mid, p_hi, err
  );

  modport master (
    output in_valid, a_in, b_in, sub_ready, prod_valid, prod_in, prod_tag, out_ready,
    input  in_ready, sub_valid, sub_a, sub_b, sub_tag, out_valid, p_lo, p_mid, p_hi, err
  );
endinterface

// File: rtl/ka_split_sched_48bit.sv
// rtl/ka_split_sched_48bit.sv - issues three Karatsuba sub-operand pairs, collects the sub-products and corrects the middle term
module ka_split_sched_48bit #(
  parameter int N = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  ka_split_sched_48bit_if.slave bus
);
  localparam int H = N / 2;
  localparam int P = 2 * H - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]     idx_q, idx_d;
  logic [2:0]     mask_q, mask_d;
  logic [P-1:0]   lo_q, lo_d, mid_q, mid_d, hi_q, hi_d;
  logic [P-1:0]   p_lo_q, p_lo_d, p_mid_q, p_mid_d, p_hi_q, p_hi_d;
  logic           in_ready_q, in_ready_d;
  logic           sub_valid_q, sub_valid_d;
  logic [H-1:0]   sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic [1:0]     sub_tag_q, sub_tag_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;

  logic [1:0]     idx_nx;
  logic [1:0]     issued;
  logic [3:0]     mask_ext;
  logic           prod_ok;
  logic           done_entry;

  function automatic logic [2*H-1:0] pair_sel(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [1:0] idx);
    logic [2*H-1:0] r;
    case (idx)
      2'd0:    r = {a[H-1:0], b[H-1:0]};
      2'd1:    r = {a[H-1:0] ^ a[N-1:H], b[H-1:0] ^ b[N-1:H]};
      default: r = {a[N-1:H], b[N-1:H]};
    endcase
    return r;
  endfunction

  // A product is legal only for a tag already handed off in an earlier cycle and not yet
  // collected; tag 3 maps onto a permanently-set mask bit so it is always rejected.
  assign idx_nx   = idx_q + 2'd1;
  assign issued   = (state_q == WAIT) ? 2'd3 : idx_q;
  assign mask_ext = {1'b1, mask_q};
  assign prod_ok  = bus.prod_valid && (state_q == ISSUE || state_q == WAIT) &&
                    (bus.prod_tag < issued) && !mask_ext[bus.prod_tag];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    lo_d        = lo_q;
    mid_d       = mid_q;
    hi_d        = hi_q;
    p_lo_d      = p_lo_q;
    p_mid_d     = p_mid_q;
    p_hi_d      = p_hi_q;
    in_ready_d  = in_ready_q;
    sub_valid_d = sub_valid_q;
    sub_a_d     = sub_a_q;
    sub_b_d     = sub_b_q;
    sub_tag_d   = sub_tag_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    done_entry  = 1'b0;

    if (bus.prod_valid && !prod_ok) err_d = 1'b1;
    if (prod_ok) begin
      case (bus.prod_tag)
        2'd0:    begin lo_d  = bus.prod_in; mask_d[0] = 1'b1; end
        2'd1:    begin mid_d = bus.prod_in; mask_d[1] = 1'b1; end
        default: begin hi_d  = bus.prod_in; mask_d[2] = 1'b1; end
      endcase
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d                = bus.a_in;
          b_d                = bus.b_in;
          mask_d             = 3'b000;
          idx_d              = 2'd0;
          in_ready_d         = 1'b0;
          sub_valid_d        = 1'b1;
          {sub_a_d, sub_b_d} = pair_sel(bus.a_in, bus.b_in, 2'd0);
          sub_tag_d          = 2'd0;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sub_ready) begin
          if (idx_q == 2'd2) begin
            sub_valid_d = 1'b0;
            if (mask_d == 3'b111) done_entry = 1'b1;
            else                  state_d    = WAIT;
          end else begin
            idx_d              = idx_nx;
            {sub_a_d, sub_b_d} = pair_sel(a_q, b_q, idx_nx);
            sub_tag_d          = idx_nx;
          end
        end
      end
      WAIT: begin
        if (mask_d == 3'b111) done_entry = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Uses the _d terms so a product landing in the entry cycle is folded in immediately.
    if (done_entry) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      p_lo_d      = lo_d;
      p_hi_d      = hi_d;
      p_mid_d     = mid_d ^ lo_d ^ hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= 2'd0;
      mask_q      <= 3'b000;
      lo_q        <= '0;
      mid_q       <= '0;
      hi_q        <= '0;
      p_lo_q      <= '0;
      p_mid_q     <= '0;
      p_hi_q      <= '0;
      in_ready_q  <= 1'b1;
      sub_valid_q <= 1'b0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      sub_tag_q   <= 2'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      lo_q        <= lo_d;
      mid_q       <= mid_d;
      hi_q        <= hi_d;
      p_lo_q      <= p_lo_d;
      p_mid_q     <= p_mid_d;
      p_hi_q      <= p_hi_d;
      in_ready_q  <= in_ready_d;
      sub_valid_q <= sub_valid_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      sub_tag_q   <= sub_tag_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sub_valid = sub_valid_q;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.sub_tag   = sub_tag_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p_lo      = p_lo_q;
  assign bus.p_mid     = p_mid_q;
  assign bus.p_hi      = p_hi_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ka_split_sched_48bit.sv
// tb/tb_ka_split_sched_48bit.sv - scoreboard bench for the Karatsuba split sequencer
module tb_ka_split_sched_48bit;
  localparam int H = 24;
  localparam int P = 47;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ka_split_sched_48bit_if bus();
  ka_split_sched_48bit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [P-1:0] lo;
    logic [P-1:0] mid;
    logic [P-1:0] hi;
    logic [94:0]  full;
    int           out_cyc;
  } exp_t;

  typedef struct {
    logic [H-1:0] a;
    logic [H-1:0] b;
    logic [1:0]   tag;
  } pair_t;

  exp_t  exp_q[$];
  pair_t pair_q[$];
  exp_t  last_exp;

  int n_cmp  = 0;
  int n_fail = 0;
  int out_stall = 0;
  int last_prod_cyc = 0;
  logic [H-1:0] cap_a [4];
  logic [H-1:0] cap_b [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [94:0] clmul(input logic [47:0] a, input logic [47:0] b);
    logic [94:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      if (b[i]) r = r ^ ({47'd0, a} << i);
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [47:0] a, input logic [47:0] b);
    exp_t        e;
    logic [94:0] t;
    t     = clmul({24'd0, a[23:0]}, {24'd0, b[23:0]});
    e.lo  = t[46:0];
    t     = clmul({24'd0, a[47:24]}, {24'd0, b[47:24]});
    e.hi  = t[46:0];
    t     = clmul({24'd0, a[23:0] ^ a[47:24]}, {24'd0, b[23:0] ^ b[47:24]});
    e.mid = t[46:0] ^ e.lo ^ e.hi;
    e.full = clmul(a, b);
    e.out_cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [47:0] a, input logic [47:0] b);
    bit    hit;
    bit    ok;
    pair_t p;
    p.a = a[23:0];            p.b = b[23:0];            p.tag = 2'd0; pair_q.push_back(p);
    p.a = a[23:0] ^ a[47:24]; p.b = b[23:0] ^ b[47:24]; p.tag = 2'd1; pair_q.push_back(p);
    p.a = a[47:24];           p.b = b[47:24];           p.tag = 2'd2; pair_q.push_back(p);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      hit = bus.in_ready;
      tick();
      if (hit) begin ok = 1'b1; break; end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("in_handshake_timeout", 0, 1);
  endtask

  task automatic issue_one(input int stall);
    bit hit;
    bit ok;
    repeat (stall) tick();
    bus.sub_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      hit = bus.sub_valid;
      if (hit) begin
        cap_a[bus.sub_tag] = bus.sub_a;
        cap_b[bus.sub_tag] = bus.sub_b;
      end
      tick();
      if (hit) begin ok = 1'b1; break; end
    end
    bus.sub_ready = 1'b0;
    if (!ok) chk("sub_handshake_timeout", 0, 1);
  endtask

  task automatic send_prod(input logic [1:0] tag, input logic [P-1:0] data);
    bus.prod_valid = 1'b1;
    bus.prod_tag   = tag;
    bus.prod_in    = data;
    last_prod_cyc  = cyc;
    tick();
    bus.prod_valid = 1'b0;
  endtask

  task automatic run_op(input logic [47:0] a, input logic [47:0] b, input int order [3],
                        input int stall, input int gap_max, input bit dup);
    exp_t        e;
    logic [94:0] t;
    start_op(a, b);
    for (int k = 0; k < 3; k++) issue_one(stall);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      t = clmul({24'd0, cap_a[order[k]]}, {24'd0, cap_b[order[k]]});
      send_prod(2'(order[k]), t[46:0]);
      if (dup && k == 0) send_prod(2'(order[k]), ~t[46:0]);
    end
    e = mk_exp(a, b);
    e.out_cyc = last_prod_cyc + 1;
    exp_q.push_back(e);
    last_exp = e;
    for (int w = 0; w < 200; w++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("result_drained", exp_q.size(), 0);
    chk("three_handshakes", pair_q.size(), 0);
    exp_q.delete();
    pair_q.delete();
  endtask

  // Sub-operand monitor: hold-stability under backpressure and pair order/content.
  initial begin : sub_mon
    bit    prev;
    pair_t held;
    pair_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sub_valid) begin
        if (prev) begin
          chk("sub_a_stable", bus.sub_a, held.a);
          chk("sub_b_stable", bus.sub_b, held.b);
          chk("sub_tag_stable", bus.sub_tag, held.tag);
        end
        if (bus.sub_ready) begin
          prev = 1'b0;
          if (pair_q.size() == 0) chk("sub_unexpected", 1, 0);
          else begin
            e = pair_q.pop_front();
            chk("sub_a", bus.sub_a, e.a);
            chk("sub_b", bus.sub_b, e.b);
            chk("sub_tag", bus.sub_tag, e.tag);
          end
        end else begin
          prev = 1'b1;
          held.a = bus.sub_a; held.b = bus.sub_b; held.tag = bus.sub_tag;
        end
      end else prev = 1'b0;
    end
  end

  // Result monitor and downstream sink with configurable out_ready stall.
  initial begin : out_mon
    bit           seen;
    int           wait_cnt;
    logic [P-1:0] s_lo, s_mid, s_hi;
    logic [94:0]  recomb;
    exp_t         e;
    seen = 1'b0;
    wait_cnt = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_ready) begin
        bus.out_ready = 1'b0;
        seen = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_rise", bus.in_ready, 1);
      end else if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          wait_cnt = 0;
          s_lo = bus.p_lo; s_mid = bus.p_mid; s_hi = bus.p_hi;
          if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
          else begin
            e = exp_q[0];
            chk("p_lo", bus.p_lo, e.lo);
            chk("p_mid", bus.p_mid, e.mid);
            chk("p_hi", bus.p_hi, e.hi);
            recomb = {48'd0, bus.p_lo} ^ ({48'd0, bus.p_mid} << 24) ^ ({48'd0, bus.p_hi} << 48);
            chk("recombined_product", recomb, e.full);
            chk("out_latency", cyc, e.out_cyc);
          end
        end else begin
          chk("p_lo_stable", bus.p_lo, s_lo);
          chk("p_mid_stable", bus.p_mid, s_mid);
          chk("p_hi_stable", bus.p_hi, s_hi);
        end
        if (wait_cnt >= out_stall) bus.out_ready = 1'b1;
        else wait_cnt++;
      end
    end
  end

  initial begin : stim
    int          ord [3];
    int          tmp;
    int          j;
    logic [47:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.sub_ready = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod_in = '0;
    bus.prod_tag = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sub_valid", bus.sub_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_p_terms", {bus.p_lo, bus.p_mid, bus.p_hi}, 0);
    tick();

    ord = '{0, 1, 2};
    run_op(48'h000000_000003, 48'h000000_000005, ord, 0, 0, 0);
    chk("basic_p_lo", bus.p_lo, 47'hF);
    chk("basic_p_mid", bus.p_mid, 0);
    chk("basic_p_hi", bus.p_hi, 0);

    run_op(48'h000001_000001, 48'h000001_000001, ord, 0, 1, 0);
    chk("square_p_lo", bus.p_lo, 1);
    chk("square_p_mid", bus.p_mid, 0);
    chk("square_p_hi", bus.p_hi, 1);

    run_op(48'h000000_000003, 48'h000000_000005, ord, 5, 0, 0);
    chk("bp_p_lo", bus.p_lo, 47'hF);

    ord = '{2, 0, 1};
    run_op({16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, ord, 0, 3, 0);

    out_stall = 4;
    ord = '{1, 2, 0};
    run_op({16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, ord, 1, 2, 0);
    out_stall = 0;

    for (int n = 0; n < 10; n++) begin
      ord = '{0, 1, 2};
      for (int i = 2; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      ra = {16'($urandom()), $urandom()};
      rb = (n == 3) ? ra : {16'($urandom()), $urandom()};
      out_stall = $urandom_range(3, 0);
      run_op(ra, rb, ord, $urandom_range(2, 0), 3, 0);
    end
    out_stall = 0;
    chk("err_clean", bus.err, 0);

    ord = '{0, 1, 2};
    run_op({16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, ord, 0, 1, 1);
    chk("err_dup_tag", bus.err, 1);
    send_prod(2'd1, 47'h123);
    tick();
    chk("err_idle_prod", bus.err, 1);
    chk("idle_p_lo_held", bus.p_lo, last_exp.lo);
    chk("idle_p_mid_held", bus.p_mid, last_exp.mid);
    chk("idle_p_hi_held", bus.p_hi, last_exp.hi);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared_by_rst", bus.err, 0);

    start_op(48'h123456_789ABC, 48'hFEDCBA_987654);
    issue_one(0);
    issue_one(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midop_rst_in_ready", bus.in_ready, 1);
    chk("midop_rst_sub_valid", bus.sub_valid, 0);
    chk("midop_rst_out_valid", bus.out_valid, 0);
    pair_q.delete();
    tick();
    ord = '{1, 0, 2};
    run_op({16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, ord, 0, 2, 0);
    chk("post_rst_err", bus.err, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
